// File: rtl/spi_pixel_pkg.sv
// spi_pixel_pkg: command opcodes, parser states and pixel type
// shared by the SPI pixel decoder and its window/cursor unit.
package spi_pixel_pkg;

    localparam logic [7:0] CMD_NOP   = 8'h00;
    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARGS,
        ST_CNT,
        ST_PIX_HI,
        ST_PIX_LO
    } state_e;

    typedef logic [15:0] rgb565_t;

endpackage

// File: rtl/spi_pixel_decoder_window_cursor.sv
// window_cursor: drawing window, cursor and row base; produces the
// framebuffer address with incremental (multiply-free) stepping.
module window_cursor #(
    parameter int WIDTH     = 240,
    parameter int HEIGHT    = 320,
    parameter int ADDR_BITS = 17,
    parameter int XW        = $clog2(WIDTH),
    parameter int YW        = $clog2(HEIGHT),
    parameter int CW        = (XW > YW) ? XW : YW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 commit_x_i,
    input  logic                 commit_y_i,
    input  logic [CW-1:0]        lo_i,
    input  logic [CW-1:0]        hi_i,
    input  logic                 load_i,
    input  logic                 step_i,
    output logic [ADDR_BITS-1:0] fb_addr_o
);

    logic [XW-1:0]        x0_q, x0_d, x1_q, x1_d, x_q, x_d;
    logic [YW-1:0]        y0_q, y0_d, y1_q, y1_d, y_q, y_d;
    logic [ADDR_BITS-1:0] top_q, top_d, row_q, row_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;

    always_comb begin
        x0_d   = x0_q;
        x1_d   = x1_q;
        x_d    = x_q;
        y0_d   = y0_q;
        y1_d   = y1_q;
        y_d    = y_q;
        top_d  = top_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (commit_x_i) begin
            x0_d = lo_i[XW-1:0];
            x1_d = hi_i[XW-1:0];
        end
        if (commit_y_i) begin
            y0_d  = lo_i[YW-1:0];
            y1_d  = hi_i[YW-1:0];
            // top-of-window base: the only multiply in the datapath
            top_d = ADDR_BITS'(32'(lo_i[YW-1:0]) * 32'(WIDTH));
        end
        if (load_i) begin
            x_d   = x0_q;
            y_d   = y0_q;
            row_d = top_q;
        end
        if (step_i) begin
            addr_d = row_q + ADDR_BITS'(x_q);
            if (x_q == x1_q) begin
                x_d = x0_q;
                if (y_q == y1_q) begin
                    y_d   = y0_q;
                    row_d = top_q;
                end else begin
                    y_d   = y_q + YW'(1);
                    row_d = row_q + ADDR_BITS'(WIDTH);
                end
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0_q   <= '0;
            x1_q   <= XW'(WIDTH - 1);
            x_q    <= '0;
            y0_q   <= '0;
            y1_q   <= YW'(HEIGHT - 1);
            y_q    <= '0;
            top_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            x0_q   <= x0_d;
            x1_q   <= x1_d;
            x_q    <= x_d;
            y0_q   <= y0_d;
            y1_q   <= y1_d;
            y_q    <= y_d;
            top_q  <= top_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

    assign fb_addr_o = addr_q;

endmodule

// File: rtl/spi_pixel_decoder.sv
// spi_pixel_decoder: ILI9341-style byte command parser emitting RGB565
// framebuffer writes, with an inactivity timeout to resync the parser.
module spi_pixel_decoder
    import spi_pixel_pkg::*;
#(
    parameter int WIDTH          = 240,
    parameter int HEIGHT         = 320,
    parameter int ADDR_BITS      = $clog2(WIDTH * HEIGHT),
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic [ADDR_BITS-1:0] fb_addr,
    output rgb565_t              fb_data,
    output logic                 fb_we,
    output logic                 busy,
    output logic                 err
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int CW = (XW > YW) ? XW : YW;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic          page_q, page_d;
    logic [23:0]   arg_q, arg_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [7:0]    hi_q, hi_d;
    logic [TW-1:0] to_q, to_d;
    logic          we_q, we_d;
    rgb565_t       data_q, data_d;
    logic          err_q, err_d;

    logic          commit_x, commit_y, load, step;
    logic [15:0]   lo_w, hi_w, n_w;
    logic          win_ok;

    assign lo_w   = arg_q[23:8];
    assign hi_w   = {arg_q[7:0], in_data};
    assign n_w    = {cnt_q[15:8], in_data};
    assign win_ok = (lo_w <= hi_w) &&
                    (hi_w < (page_q ? 16'(HEIGHT) : 16'(WIDTH)));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        page_d   = page_q;
        arg_d    = arg_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        to_d     = '0;
        we_d     = 1'b0;
        data_d   = data_q;
        err_d    = 1'b0;
        commit_x = 1'b0;
        commit_y = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        if (state_q != ST_IDLE && !in_valid) begin
            to_d = to_q + TW'(1);
        end
        if (in_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    idx_d = '0;
                    case (in_data)
                        CMD_NOP: ;
                        CMD_CASET: begin
                            state_d = ST_ARGS;
                            page_d  = 1'b0;
                        end
                        CMD_PASET: begin
                            state_d = ST_ARGS;
                            page_d  = 1'b1;
                        end
                        CMD_RAMWR: state_d = ST_CNT;
                        default:   err_d   = 1'b1;
                    endcase
                end
                ST_ARGS: begin
                    arg_d = {arg_q[15:0], in_data};
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = ST_IDLE;
                        if (win_ok) begin
                            commit_x = !page_q;
                            commit_y = page_q;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_CNT: begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd0) begin
                        cnt_d = {in_data, cnt_q[7:0]};
                    end else begin
                        cnt_d   = n_w;
                        load    = 1'b1;
                        state_d = (n_w == 16'd0) ? ST_IDLE : ST_PIX_HI;
                    end
                end
                ST_PIX_HI: begin
                    hi_d    = in_data;
                    state_d = ST_PIX_LO;
                end
                ST_PIX_LO: begin
                    we_d    = 1'b1;
                    data_d  = {hi_q, in_data};
                    step    = 1'b1;
                    cnt_d   = cnt_q - 16'd1;
                    state_d = (cnt_q == 16'd1) ? ST_IDLE : ST_PIX_HI;
                end
            endcase
        end else if (state_q != ST_IDLE && to_q == TO_LAST) begin
            // a lost byte must not leave a stale high half behind
            state_d = ST_IDLE;
            err_d   = 1'b1;
            hi_d    = '0;
            to_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            page_q  <= 1'b0;
            arg_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            to_q    <= '0;
            we_q    <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            page_q  <= page_d;
            arg_q   <= arg_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            to_q    <= to_d;
            we_q    <= we_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    window_cursor #(
        .WIDTH     (WIDTH),
        .HEIGHT    (HEIGHT),
        .ADDR_BITS (ADDR_BITS)
    ) u_cursor (
        .clk        (clk),
        .rst        (rst),
        .commit_x_i (commit_x),
        .commit_y_i (commit_y),
        .lo_i       (CW'(lo_w)),
        .hi_i       (CW'(hi_w)),
        .load_i     (load),
        .step_i     (step),
        .fb_addr_o  (fb_addr)
    );

    assign fb_data = data_q;
    assign fb_we   = we_q;
    assign err     = err_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_pixel_decoder.sv
// tb_spi_pixel_decoder: byte vectors with expected per-byte outputs,
// plus timeout, simultaneous-event and mid-packet reset sequences.
module tb_spi_pixel_decoder;

    localparam int TO = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic [16:0] fb_addr;
    logic [15:0] fb_data;
    logic        fb_we;
    logic        busy;
    logic        err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_pixel_decoder #(
        .WIDTH          (240),
        .HEIGHT         (320),
        .ADDR_BITS      (17),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .fb_we    (fb_we),
        .busy     (busy),
        .err      (err)
    );

    typedef struct {
        logic        pre_rst;
        logic [7:0]  data;
        logic        we;
        logic [16:0] addr;
        logic [15:0] pix;
        logic        err;
        logic        busy;
    } vec_t;

    vec_t vq[$];

    task automatic addb(input logic r, input logic [7:0] d,
                        input logic e, input logic b);
        vec_t v;
        v.pre_rst = r;
        v.data    = d;
        v.we      = 1'b0;
        v.addr    = '0;
        v.pix     = '0;
        v.err     = e;
        v.busy    = b;
        vq.push_back(v);
    endtask

    task automatic addw(input logic [7:0] d, input logic [16:0] a,
                        input logic [15:0] p, input logic b);
        vec_t v;
        v.pre_rst = 1'b0;
        v.data    = d;
        v.we      = 1'b1;
        v.addr    = a;
        v.pix     = p;
        v.err     = 1'b0;
        v.busy    = b;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, d);
    endtask

    initial begin
        bit seen;
        bit we_seen;
        int k;

        // basic two-pixel write from reset
        addb(1, 8'h2C, 0, 1);
        addb(0, 8'h00, 0, 1);
        addb(0, 8'h02, 0, 1);
        addb(0, 8'hF8, 0, 1);
        addw(8'h00, 17'd0, 16'hF800, 1);
        addb(0, 8'h07, 0, 1);
        addw(8'hE0, 17'd1, 16'h07E0, 0);
        // 2x2 window with wrap to window top
        addb(0, 8'h2A, 0, 1);
        addb(0, 8'h00, 0, 1);
        addb(0, 8'h0A, 0, 1);
        addb(0, 8'h00, 0, 1);
        addb(0, 8'h0B, 0, 0);
        addb(0, 8'h2B, 0, 1);
        addb(0, 8'h00, 0, 1);
        addb(0, 8'h05, 0, 1);
        addb(0, 8'h00, 0, 1);
        addb(0, 8'h06, 0, 0);
        addb(0, 8'h2C, 0, 1);
        addb(0, 8'h00, 0, 1);
        addb(0, 8'h05, 0, 1);
        addb(0, 8'h11, 0, 1);
        addw(8'h22, 17'd1210, 16'h1122, 1);
        addb(0, 8'h33, 0, 1);
        addw(8'h44, 17'd1211, 16'h3344, 1);
        addb(0, 8'h55, 0, 1);
        addw(8'h66, 17'd1450, 16'h5566, 1);
        addb(0, 8'h77, 0, 1);
        addw(8'h88, 17'd1451, 16'h7788, 1);
        addb(0, 8'h99, 0, 1);
        addw(8'hAA, 17'd1210, 16'h99AA, 0);
        // x0 > x1 rejected, window unchanged
        addb(1, 8'h2A, 0, 1);
        addb(0, 8'h00, 0, 1);
        addb(0, 8'h14, 0, 1);
        addb(0, 8'h00, 0, 1);
        addb(0, 8'h0A, 1, 0);
        addb(0, 8'h2C, 0, 1);
        addb(0, 8'h00, 0, 1);
        addb(0, 8'h01, 0, 1);
        addb(0, 8'hAB, 0, 1);
        addw(8'hCD, 17'd0, 16'hABCD, 0);
        // y1 = HEIGHT rejected
        addb(0, 8'h2B, 0, 1);
        addb(0, 8'h01, 0, 1);
        addb(0, 8'h40, 0, 1);
        addb(0, 8'h01, 0, 1);
        addb(0, 8'h40, 1, 0);
        // unknown opcode, NOP, zero-length write
        addb(1, 8'h55, 1, 0);
        addb(0, 8'h00, 0, 0);
        addb(0, 8'h2C, 0, 1);
        addb(0, 8'h00, 0, 1);
        addb(0, 8'h00, 0, 0);
        // single-pixel window at the bottom-right corner
        addb(1, 8'h2A, 0, 1);
        addb(0, 8'h00, 0, 1);
        addb(0, 8'hEF, 0, 1);
        addb(0, 8'h00, 0, 1);
        addb(0, 8'hEF, 0, 0);
        addb(0, 8'h2B, 0, 1);
        addb(0, 8'h01, 0, 1);
        addb(0, 8'h3F, 0, 1);
        addb(0, 8'h01, 0, 1);
        addb(0, 8'h3F, 0, 0);
        addb(0, 8'h2C, 0, 1);
        addb(0, 8'h00, 0, 1);
        addb(0, 8'h02, 0, 1);
        addb(0, 8'h12, 0, 1);
        addw(8'h34, 17'd76799, 16'h1234, 1);
        addb(0, 8'h56, 0, 1);
        addw(8'h78, 17'd76799, 16'h5678, 0);

        #3;
        rst = 1'b1;
        #1;
        chk("reset_addr", 32'(fb_addr), 32'd0);
        chk("reset_data", 32'(fb_data), 32'd0);
        chk("reset_we", 32'(fb_we), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[i]) begin
            if (vq[i].pre_rst) do_reset();
            send(vq[i].data);
            chk($sformatf("vec%0d_we", i), 32'(fb_we), 32'(vq[i].we));
            if (vq[i].we) begin
                chk($sformatf("vec%0d_addr", i), 32'(fb_addr), 32'(vq[i].addr));
                chk($sformatf("vec%0d_data", i), 32'(fb_data), 32'(vq[i].pix));
            end
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vq[i].err));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vq[i].busy));
        end

        // timeout after a truncated pixel
        do_reset();
        send(8'h2C);
        send(8'h00);
        send(8'h03);
        send(8'hAA);
        seen = 0;
        we_seen = 0;
        k = 0;
        for (int i = 1; i <= TO + 20 && !seen; i++) begin
            step(1'b0, 8'h00);
            if (fb_we) we_seen = 1;
            if (err) begin
                seen = 1;
                k = i;
            end
        end
        chk("to_seen", 32'(seen), 32'd1);
        chk("to_cycle", 32'(k), 32'(TO));
        chk("to_no_we", 32'(we_seen), 32'd0);
        chk("to_busy", 32'(busy), 32'd0);
        step(1'b0, 8'h00);
        chk("to_err_once", 32'(err), 32'd0);
        send(8'h2C);
        send(8'h00);
        send(8'h01);
        send(8'h12);
        send(8'h34);
        chk("to_next_we", 32'(fb_we), 32'd1);
        chk("to_next_addr", 32'(fb_addr), 32'd0);
        chk("to_next_data", 32'(fb_data), 32'h1234);

        // byte arriving on the expiry cycle wins
        do_reset();
        send(8'h2C);
        send(8'h00);
        send(8'h02);
        send(8'hAA);
        seen = 0;
        for (int i = 1; i <= TO - 1; i++) begin
            step(1'b0, 8'h00);
            if (err) seen = 1;
        end
        chk("sim_no_early_err", 32'(seen), 32'd0);
        send(8'hBB);
        chk("sim_we", 32'(fb_we), 32'd1);
        chk("sim_err", 32'(err), 32'd0);
        chk("sim_data", 32'(fb_data), 32'hAABB);
        chk("sim_busy", 32'(busy), 32'd1);
        send(8'hCC);
        send(8'hDD);
        chk("sim_addr2", 32'(fb_addr), 32'd1);
        chk("sim_busy2", 32'(busy), 32'd0);

        // reset during PIX_LO of a 4-pixel burst
        do_reset();
        send(8'h2A);
        send(8'h00);
        send(8'h05);
        send(8'h00);
        send(8'h09);
        send(8'h2C);
        send(8'h00);
        send(8'h04);
        send(8'h01);
        send(8'h02);
        chk("mr_addr_pre", 32'(fb_addr), 32'd5);
        send(8'h03);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mr_addr", 32'(fb_addr), 32'd0);
        chk("mr_data", 32'(fb_data), 32'd0);
        chk("mr_we", 32'(fb_we), 32'd0);
        chk("mr_err", 32'(err), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send(8'h2C);
        send(8'h00);
        send(8'h01);
        send(8'h56);
        send(8'h78);
        chk("mr_next_we", 32'(fb_we), 32'd1);
        chk("mr_next_addr", 32'(fb_addr), 32'd0);
        chk("mr_next_data", 32'(fb_data), 32'h5678);
        chk("mr_next_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_pixel_decoder.md
Name: spi_pixel_decoder

Overview:
- Byte-stream command parser that sits directly downstream of the SPI byte deserializer.
- Consumes its 8-bit data plus single-cycle ready strobe and interprets ILI9341-style commands: column window, page window and memory write.
- Emits RGB565 framebuffer write requests with auto-incrementing, window-wrapping addresses.
- Includes an inactivity timeout that resynchronises the parser after a lost or truncated packet.

Parameters:
- WIDTH, 240, display columns.
- HEIGHT, 320, display rows.
- ADDR_BITS, $clog2(WIDTH*HEIGHT) (17), framebuffer address width.
- TIMEOUT_CYCLES, 4096, idle clk cycles tolerated mid-packet before abort.

Ports:
- clk  input  1  system clock (same domain as the upstream data_ready)
- rst  input  1  asynchronous, active-high reset
- in_data  input  8  received byte
- in_valid  input  1  one-cycle strobe, in_data valid this cycle; may assert on consecutive cycles
- fb_addr  output  ADDR_BITS  framebuffer word address, y*WIDTH + x
- fb_data  output  16  RGB565 pixel, first byte received is [15:8]
- fb_we  output  1  one-cycle write strobe
- busy  output  1  high whenever state != IDLE
- err  output  1  one-cycle pulse on protocol error

Behaviour:
- Reset (async):
  - state=IDLE; fb_addr=0, fb_data=0, fb_we=0, err=0.
  - Window x0=0, x1=WIDTH-1, y0=0, y1=HEIGHT-1; cursor=(0,0); count=0; timeout counter=0.
- Commands, only recognised in IDLE:
  - 0x00: NOP, no effect.
  - 0x2A: column set. Four argument bytes follow, x0 hi, x0 lo, x1 hi, x1 lo.
  - 0x2B: page set, same byte layout, for y0/y1.
  - 0x2C: memory write. Count hi and count lo follow (N pixels), then 2N pixel bytes.
  - Any other byte: err pulse the following cycle; stay IDLE.
- States: IDLE, ARGS (byte index 0..3), CNT (index 0..1), PIX_HI, PIX_LO.
- Window commit on the 4th ARGS byte:
  - Accept only if lo<=hi and hi<limit (WIDTH or HEIGHT).
  - Otherwise keep the old window and pulse err.
  - Return to IDLE either way.
  - A precomputed row base, y0*WIDTH, is updated on page commit; this is the only multiply.
- 0x2C entry:
  - Cursor is set to (x0,y0) and the row base to y0*WIDTH on the 2nd count byte.
  - N==0 returns to IDLE with no writes; otherwise go to PIX_HI.
- Pixel handling:
  - PIX_HI latches the byte.
  - On the PIX_LO byte, the cycle after that in_valid: fb_we=1 for exactly one cycle, fb_addr=row_base+x, fb_data={hi,lo}.
  - Latency is one cycle.
- Cursor advance after each pixel:
  - If x==x1: x=x0 and y advances; otherwise x++.
  - When y advances and y==y1: y=y0 and row base = y0*WIDTH (wrap to window top); otherwise y++ and row base += WIDTH.
  - Decrement count; at 0 go to IDLE, else PIX_HI.
- Address arithmetic: incremental only, no per-pixel multiply. Count is 16 bits; N=65535 is legal and wraps the window as needed.
- Timeout:
  - The counter clears on every in_valid and increments each idle cycle while state!=IDLE.
  - On reaching TIMEOUT_CYCLES: state=IDLE, err pulse, any latched PIX_HI byte discarded, no fb_we.
  - Counter held at 0 in IDLE.
- Simultaneous events: in_valid in the same cycle as timeout expiry means the byte wins, the counter clears and there is no abort.
- Reset mid-packet: immediate return to IDLE. Window registers return to full screen.
- fb_we and err are never high for two consecutive cycles from one event. Back-to-back in_valid is processed one byte per cycle.

Decomposition:
- Package spi_pixel_pkg:
  - Command opcodes CMD_NOP=8'h00, CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C.
  - State enum.
  - RGB565 pixel typedef (16 bits).
- One natural sub-module, window_cursor:
  - Holds x0/x1/y0/y1, cursor, row base and the advance/wrap logic.
  - Inputs are commit and load/step strobes; output is fb_addr.
- The parser FSM and timeout stay in the top module.

Test Plan:
- Reset then 0x2C,0x00,0x02,0xF8,0x00,0x07,0xE0 -> fb_we pulses at addr 0 data 0xF800, then addr 1 data 0x07E0; busy falls after the 2nd pixel.
- 0x2A,0,10,0,11; 0x2B,0,5,0,6; 0x2C,0,5 + 10 bytes -> addrs 1210,1211,1450,1451,1210; the 5th write wraps to the window top.
- 0x2A,0,20,0,10 (x0>x1) -> err pulse, no window change; a following 1-pixel RAMWR writes addr 0.
- 0x2C,0,3,0xAA then silence for TIMEOUT_CYCLES -> err pulse, busy=0, no fb_we; the next 0x2C,0,1,0x12,0x34 writes 0x1234 at addr 0.
- Byte 0x55 in IDLE -> err one cycle later; 0x00 -> no err; 0x2C,0,0 -> no writes, busy low after the count.
- Assert rst during PIX_LO of a 4-pixel burst -> all outputs 0 immediately, window full screen, the next command parsed normally.
